ascii_num_parser: RTL

//  Stage directly downstream of ascii_validator. On start, walks the validated character

---
 rtl/ascii_num_parser_if.sv | 32 +++
 rtl/ascii_num_parser.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ascii_num_parser_if.sv
// Bus bundle between the parser, its character buffer read port and the
// downstream integer consumer; clk/rst stay plain ports on the modules.
interface ascii_num_parser_if #(
  parameter int unsigned MAX_PAYLOAD = 2048,
  parameter int unsigned DATA_WIDTH  = 32
);
  localparam int unsigned AW = $clog2(MAX_PAYLOAD);

  logic                  start;
  logic [15:0]           buffer_length;
  logic [AW-1:0]         rd_addr;
  logic [7:0]            rd_data;
  logic [DATA_WIDTH-1:0] num_data;
  logic                  num_valid;
  logic                  num_ready;
  logic [15:0]           num_count;
  logic                  busy;
  logic                  done;
  logic                  error;

  // Parser side
  modport master (
    input  start, buffer_length, rd_data, num_ready,
    output rd_addr, num_data, num_valid, num_count, busy, done, error
  );

  // Environment side: controller, char buffer and integer consumer
  modport slave (
    output start, buffer_length, rd_data, num_ready,
    input  rd_addr, num_data, num_valid, num_count, busy, done, error
  );
endinterface

// File: rtl/ascii_num_parser.sv
// Walks a validated character buffer (digits, ' ', '-') and streams each
// space-separated signed decimal token out as a two's-complement integer.
module ascii_num_parser #(
  parameter int unsigned MAX_PAYLOAD = 2048,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               rst,
  ascii_num_parser_if.master bus
);
  localparam int unsigned AW = $clog2(MAX_PAYLOAD);
  localparam int unsigned MW = DATA_WIDTH + 1;
  localparam int unsigned PW = DATA_WIDTH + 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_PROC,
    S_EMIT,
    S_FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           idx_q, idx_d;
  logic [MW-1:0]         mag_q, mag_d;
  logic                  neg_q, neg_d;
  logic                  in_tok_q, in_tok_d;
  logic                  last_q, last_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] num_data_q, num_data_d;
  logic                  num_valid_q, num_valid_d;
  logic [15:0]           num_count_q, num_count_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [PW-1:0]         prod;
  logic [PW-1:0]         limit;
  logic                  is_digit;
  logic                  is_minus;
  logic                  is_space;
  logic                  is_nul;
  logic                  eod;
  logic                  fail;
  logic                  emit;

  // Accumulate in a wider product so overflow is detected rather than wrapped
  assign prod     = PW'(mag_q) * PW'(10) + PW'(bus.rd_data[3:0]);
  assign limit    = (PW'(1) << (DATA_WIDTH - 1)) - PW'(!neg_q);
  assign is_digit = (bus.rd_data >= 8'h30) && (bus.rd_data <= 8'h39);
  assign is_minus = (bus.rd_data == 8'h2d);
  assign is_space = (bus.rd_data == 8'h20);
  assign is_nul   = (bus.rd_data == 8'h00);
  assign eod      = (({1'b0, idx_q} + 17'd1) == {1'b0, len_q});

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    in_tok_d    = in_tok_q;
    last_d      = last_q;
    num_data_d  = num_data_q;
    num_valid_d = num_valid_q;
    num_count_d = num_count_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    fail        = 1'b0;
    emit        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d       = bus.buffer_length;
          idx_d       = 16'd0;
          mag_d       = '0;
          neg_d       = 1'b0;
          in_tok_d    = 1'b0;
          last_d      = 1'b0;
          num_count_d = 16'd0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (bus.buffer_length == 16'd0) ? S_FINISH : S_READ;
        end
      end

      S_READ: state_d = S_PROC;

      // rd_data now holds the character at idx_q
      S_PROC: begin
        idx_d   = idx_q + 16'd1;
        state_d = S_READ;
        if (is_digit) begin
          if (prod > limit) begin
            fail = 1'b1;
          end else begin
            mag_d    = MW'(prod);
            in_tok_d = 1'b1;
            if (eod) begin
              emit   = 1'b1;
              last_d = 1'b1;
            end
          end
        end else if (is_minus) begin
          if (in_tok_q || neg_q || eod) fail = 1'b1;
          else                          neg_d = 1'b1;
        end else if (is_space) begin
          if (in_tok_q) begin
            emit   = 1'b1;
            last_d = eod;
          end else if (neg_q) begin
            fail = 1'b1;
          end else if (eod) begin
            state_d = S_FINISH;
          end
        end else if (is_nul) begin
          if (in_tok_q) begin
            emit   = 1'b1;
            last_d = 1'b1;
          end else if (neg_q) begin
            fail = 1'b1;
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          fail = 1'b1;
        end
      end

      S_EMIT: begin
        if (num_valid_q && bus.num_ready) begin
          num_valid_d = 1'b0;
          num_count_d = num_count_q + 16'd1;
          mag_d       = '0;
          neg_d       = 1'b0;
          in_tok_d    = 1'b0;
          state_d     = last_q ? S_FINISH : S_READ;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      state_d     = S_EMIT;
      num_valid_d = 1'b1;
      num_data_d  = neg_d ? DATA_WIDTH'(-mag_d) : DATA_WIDTH'(mag_d);
    end

    // Partial token is simply dropped; emitted integers stand
    if (fail) begin
      error_d = 1'b1;
      state_d = S_FINISH;
    end

    if ((state_d == S_FINISH) && (state_q != S_FINISH)) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end

    // Address tracks idx so the READ cycle presents it to the 1-cycle buffer
    rd_addr_d = AW'(idx_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= 16'd0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      in_tok_q    <= 1'b0;
      last_q      <= 1'b0;
      rd_addr_q   <= '0;
      num_data_q  <= '0;
      num_valid_q <= 1'b0;
      num_count_q <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      in_tok_q    <= in_tok_d;
      last_q      <= last_d;
      rd_addr_q   <= rd_addr_d;
      num_data_q  <= num_data_d;
      num_valid_q <= num_valid_d;
      num_count_q <= num_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rd_addr   = rd_addr_q;
  assign bus.num_data  = num_data_q;
  assign bus.num_valid = num_valid_q;
  assign bus.num_count = num_count_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

endmodule
